// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // clk_smp pulses per bit period; one baud generator feeds both directions.
  localparam int OVERSAMPLE = 16;

  // Transmit FSM encodings.
  typedef enum logic [2:0] {
    T_IDLE   = 3'd0,
    T_START  = 3'd1,
    T_DATA   = 3'd2,
    T_PARITY = 3'd3,
    T_STOP   = 3'd4
  } tx_state_t;

  // Receive FSM encodings, kept here so the receiver can share this package.
  typedef enum logic [0:0] {
    R_IDLE   = 1'b0,
    R_SAMPLE = 1'b1
  } rx_state_t;

  // Frame length in bit periods.
  function automatic int frame_bits(input int data_bits, input int parity_en,
                                    input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one byte per accepted request into start/data/[parity]/stop on txd.
// Latency: txd drives the start bit the clk after acceptance; txd_flag pulses as the last stop bit ends.
// Backpressure: txd_ready low from the clk after acceptance until frame end; requests while low are dropped.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   clk_smp       one-clk enable at OVERSAMPLE x baud (shared with the receiver)
//   txd_en/ready  request handshake, txd_data sampled on acceptance
//   txd           serial line, registered, idles high
//   txd_busy      high while a frame is in flight
//   txd_flag      one-clk pulse at end of frame
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_smp,
  input  logic                 txd_en,
  input  logic [DATA_BITS-1:0] txd_data,
  output logic                 txd_ready,
  output logic                 txd,
  output logic                 txd_busy,
  output logic                 txd_flag
);

  localparam logic [3:0] SMP_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic       PAR_INV   = (PARITY_ODD != 0);

  tx_state_t             state, state_nxt;
  logic [3:0]            smp_cnt, smp_cnt_nxt;
  logic [2:0]            bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0]  shift_reg, shift_nxt;
  logic                  parity_bit, parity_nxt;
  logic                  txd_nxt;
  logic                  flag_nxt;
  logic                  bit_end;

  assign txd_ready = (state == T_IDLE);
  assign txd_busy  = (state != T_IDLE);
  assign bit_end   = clk_smp && (smp_cnt == SMP_LAST);

  always_comb begin
    state_nxt   = state;
    smp_cnt_nxt = smp_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_reg;
    parity_nxt  = parity_bit;
    flag_nxt    = 1'b0;
    txd_nxt     = 1'b1;

    // The bit timer only runs inside a frame; it wraps at the bit boundary.
    if (state != T_IDLE && clk_smp) begin
      smp_cnt_nxt = bit_end ? 4'd0 : smp_cnt + 4'd1;
    end

    case (state)
      T_IDLE: begin
        if (txd_en) begin
          state_nxt   = T_START;
          smp_cnt_nxt = 4'd0;
          bit_cnt_nxt = 3'd0;
          shift_nxt   = txd_data;
          parity_nxt  = (^txd_data) ^ PAR_INV;
        end
      end
      T_START: begin
        if (bit_end) begin
          state_nxt   = T_DATA;
          bit_cnt_nxt = 3'd0;
        end
      end
      T_DATA: begin
        if (bit_end) begin
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_nxt = 3'd0;
            state_nxt   = (PARITY_EN != 0) ? T_PARITY : T_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      T_PARITY: begin
        if (bit_end) begin
          state_nxt   = T_STOP;
          bit_cnt_nxt = 3'd0;
        end
      end
      T_STOP: begin
        // bit_cnt is reused to count stop bits.
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            state_nxt   = T_IDLE;
            bit_cnt_nxt = 3'd0;
            flag_nxt    = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: state_nxt = T_IDLE;
    endcase

    // txd is decoded from the next state so the registered pin lines up
    // with the state register and carries no combinational glitches.
    case (state_nxt)
      T_START:  txd_nxt = 1'b0;
      T_DATA:   txd_nxt = shift_nxt[0];
      T_PARITY: txd_nxt = parity_nxt;
      default:  txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= T_IDLE;
      smp_cnt    <= 4'd0;
      bit_cnt    <= 3'd0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      txd        <= 1'b1;
      txd_flag   <= 1'b0;
    end else begin
      state      <= state_nxt;
      smp_cnt    <= smp_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_reg  <= shift_nxt;
      parity_bit <= parity_nxt;
      txd        <= txd_nxt;
      txd_flag   <= flag_nxt;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances (8N1, 8E2, 8O2) sharing clk and clk_smp.
// Latency: n/a.
// Backpressure: requests are only driven when the instance reports txd_ready.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int NONE = 100000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_smp = 1'b1;
  logic [2:0] en;
  logic [7:0] dat [3];
  logic [2:0] rdy, txd, busy, flag;

  int errors = 0;
  int checks = 0;

  int PE [3] = '{0, 1, 1};
  int PO [3] = '{0, 0, 1};
  int SB [3] = '{1, 2, 2};

  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .clk_smp(clk_smp), .txd_en(en[0]), .txd_data(dat[0]),
    .txd_ready(rdy[0]), .txd(txd[0]), .txd_busy(busy[0]), .txd_flag(flag[0]));
  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .clk_smp(clk_smp), .txd_en(en[1]), .txd_data(dat[1]),
    .txd_ready(rdy[1]), .txd(txd[1]), .txd_busy(busy[1]), .txd_flag(flag[1]));
  uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .clk_smp(clk_smp), .txd_en(en[2]), .txd_data(dat[2]),
    .txd_ready(rdy[2]), .txd(txd[2]), .txd_busy(busy[2]), .txd_flag(flag[2]));

  always #5 clk = ~clk;

  // clk_smp generator plus a behavioural 16x receiver watching u0's line.
  int         smp_period = 1;
  int         smp_phase  = 0;
  bit         loop_on    = 1'b0;
  bit         rx_on      = 1'b0;
  int         rx_cnt     = 0;
  logic [7:0] rx_byte    = 8'h00;
  logic [7:0] rx_q [$];
  int         rx_flags   = 0;
  int         frame_err  = 0;
  int         tx_flags   = 0;

  always @(negedge clk) begin
    if (flag[0] === 1'b1) tx_flags = tx_flags + 1;
    if (loop_on && clk_smp) begin
      if (!rx_on) begin
        if (txd[0] === 1'b0) begin
          rx_on  = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt = rx_cnt + 1;
        if (rx_cnt == 8 && txd[0] !== 1'b0) begin
          rx_on = 1'b0;
        end else if (rx_cnt > 8 && (rx_cnt - 8) % 16 == 0) begin
          if ((rx_cnt - 8) / 16 <= 8) begin
            rx_byte[(rx_cnt - 8) / 16 - 1] = txd[0];
          end else begin
            if (txd[0] !== 1'b1) frame_err = frame_err + 1;
            rx_q.push_back(rx_byte);
            rx_flags = rx_flags + 1;
            rx_on = 1'b0;
          end
        end
      end
    end
    smp_phase = (smp_phase + 1) % smp_period;
    clk_smp   = (smp_phase == 0);
  end

  // Expected line level during bit period i of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int i, input int pe, input int po);
    logic [7:0] dd;
    dd = d;
    if (i == 0) return 1'b0;
    if (i <= 8) return dd[i-1];
    if (i == 9 && pe != 0) return (^dd) ^ (po != 0);
    return 1'b1;
  endfunction

  // Sends d on unit u and checks every clk of the frame plus the end cycle.
  // predriven: the request is already on the inputs (back-to-back chaining).
  // hold: keep txd_en high with nd so the next frame follows immediately.
  task automatic frame_check(input int u, input logic [7:0] d, input bit predriven,
                             input bit hold, input logic [7:0] nd, input int pulse_at);
    int   total;
    logic exp_txd, exp_busy;
    if (!predriven) begin
      @(negedge clk);
      checks++;
      if (rdy[u] !== 1'b1) begin
        errors++;
        $display("FAIL ready_before u%0d: got %b want 1", u, rdy[u]);
      end
      en[u]  = 1'b1;
      dat[u] = d;
    end
    @(posedge clk);
    total = frame_bits(8, PE[u], SB[u]) * 16;
    for (int c = 0; c <= total; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (hold) dat[u] = nd;
        else begin
          en[u]  = 1'b0;
          dat[u] = 8'($urandom);
        end
      end
      if (c == pulse_at) begin
        en[u]  = 1'b1;
        dat[u] = 8'hFF;
      end
      if (c == pulse_at + 1) en[u] = 1'b0;
      exp_txd  = (c < total) ? exp_bit(d, c / 16, PE[u], PO[u]) : 1'b1;
      exp_busy = (c < total);
      checks++;
      if (txd[u] !== exp_txd) begin
        errors++;
        $display("FAIL txd u%0d data=%h clk=%0d: got %b want %b", u, d, c, txd[u], exp_txd);
      end
      checks++;
      if (busy[u] !== exp_busy) begin
        errors++;
        $display("FAIL busy u%0d data=%h clk=%0d: got %b want %b", u, d, c, busy[u], exp_busy);
      end
      checks++;
      if (rdy[u] !== !exp_busy) begin
        errors++;
        $display("FAIL ready u%0d data=%h clk=%0d: got %b want %b", u, d, c, rdy[u], !exp_busy);
      end
      checks++;
      if (flag[u] !== (c == total)) begin
        errors++;
        $display("FAIL flag u%0d data=%h clk=%0d: got %b want %b", u, d, c, flag[u], (c == total));
      end
    end
  endtask

  task automatic idle_check(input int u, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      checks++;
      if (txd[u] !== 1'b1 || flag[u] !== 1'b0 || rdy[u] !== 1'b1) begin
        errors++;
        $display("FAIL idle u%0d clk=%0d: got txd=%b flag=%b ready=%b want 1 0 1",
                 u, c, txd[u], flag[u], rdy[u]);
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (txd !== 3'b111) begin errors++; $display("FAIL reset_txd: got %b want 111", txd); end
    checks++;
    if (rdy !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b want 111", rdy); end
    checks++;
    if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b want 000", busy); end
    checks++;
    if (flag !== 3'b000) begin errors++; $display("FAIL reset_flag: got %b want 000", flag); end
  endtask

  task automatic test_basic;
    frame_check(0, 8'h55, 1'b0, 1'b0, 8'h00, NONE);
  endtask

  task automatic test_back_to_back;
    frame_check(0, 8'hA3, 1'b0, 1'b1, 8'h0F, NONE);
    frame_check(0, 8'h0F, 1'b1, 1'b0, 8'h00, NONE);
  endtask

  task automatic test_parity;
    frame_check(1, 8'h07, 1'b0, 1'b0, 8'h00, NONE);
    frame_check(2, 8'h07, 1'b0, 1'b0, 8'h00, NONE);
  endtask

  task automatic test_ignore_busy;
    frame_check(0, 8'h00, 1'b0, 1'b0, 8'h00, 40);
    idle_check(0, 200);
  endtask

  task automatic test_reset_midframe;
    @(negedge clk);
    en[0]  = 1'b1;
    dat[0] = 8'h3C;
    @(posedge clk);
    for (int c = 0; c <= 84; c++) begin
      @(negedge clk);
      if (c == 0) en[0] = 1'b0;
    end
    checks++;
    if (busy[0] !== 1'b1 || txd[0] !== exp_bit(8'h3C, 5, 0, 0)) begin
      errors++;
      $display("FAIL pre_reset: got busy=%b txd=%b want 1 %b", busy[0], txd[0], exp_bit(8'h3C, 5, 0, 0));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (txd[0] !== 1'b1 || rdy[0] !== 1'b1 || busy[0] !== 1'b0 || flag[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got txd=%b ready=%b busy=%b flag=%b want 1 1 0 0",
               txd[0], rdy[0], busy[0], flag[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_check(0, 20);
    frame_check(0, 8'h81, 1'b0, 1'b0, 8'h00, NONE);
  endtask

  task automatic test_random;
    int         u;
    bit         pre, hold;
    logic [7:0] d, nd;
    pre = 1'b0;
    u   = 0;
    d   = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      if (!pre) u = int'($urandom_range(0, 2));
      nd   = 8'($urandom);
      hold = (i < 5) && ($urandom_range(0, 1) == 1);
      frame_check(u, d, pre, hold, nd, NONE);
      pre = hold;
      d   = nd;
    end
  endtask

  task automatic test_loopback;
    logic [7:0] sent [4] = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
    int         waited;
    smp_period = 4;
    repeat (8) @(negedge clk);
    rx_q.delete();
    rx_flags = 0;
    tx_flags = 0;
    loop_on  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      @(negedge clk);
      while (rdy[0] !== 1'b1 && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (waited >= 2000) begin
        errors++;
        $display("FAIL loop_ready_timeout byte %0d: got ready=%b want 1", i, rdy[0]);
      end
      en[0]  = 1'b1;
      dat[0] = sent[i];
      @(negedge clk);
      en[0]  = 1'b0;
    end
    waited = 0;
    while ((rx_q.size() < 4 || tx_flags < 4) && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (rx_q.size() != 4) begin
      errors++;
      $display("FAIL loop_count: got %0d bytes want 4", rx_q.size());
    end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== sent[i]) begin
        errors++;
        $display("FAIL loop_byte %0d: got %h want %h", i, rx_q[i], sent[i]);
      end
    end
    checks++;
    if (rx_flags != tx_flags || tx_flags != 4) begin
      errors++;
      $display("FAIL loop_flags: got rx=%0d tx=%0d want 4 4", rx_flags, tx_flags);
    end
    checks++;
    if (frame_err != 0) begin
      errors++;
      $display("FAIL loop_stop_bit: got %0d framing errors want 0", frame_err);
    end
    loop_on = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 3'b000;
    for (int i = 0; i < 3; i++) dat[i] = 8'h00;
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_basic;
    test_back_to_back;
    test_parity;
    test_ignore_busy;
    test_reset_midframe;
    test_random;
    test_loopback;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
